// File: rtl/tx_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_scheduler_if
// Description : Producer handshakes and serializer-facing outputs of the TX
//               frame scheduler, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_frame_scheduler_if;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [31:0] b_data;
    logic        b_ready;
    logic        tx_start;
    logic [31:0] tx_data;
    logic        tx_busy;
    logic        grant;
    logic        frame_done;
    logic [15:0] frame_cnt;

    // Producer / observer side
    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready, tx_start, tx_data, tx_busy, grant,
               frame_done, frame_cnt
    );

    // Scheduler side
    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready, tx_start, tx_data, tx_busy, grant,
               frame_done, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_scheduler
// Description : Round-robin sharing of the 32-bit RS232 TX serializer between
//               producer A (command ack) and producer B (status/telemetry).
//               Each frame: latch word, hold start pulse, wait out the frame,
//               then enforce an idle gap before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_scheduler #(
    parameter int START_HOLD   = 2,
    parameter int FRAME_CYCLES = 48,
    parameter int GAP_CYCLES   = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    tx_frame_scheduler_if.slave   bus
);

    localparam logic [7:0] c_START_LAST = 8'(START_HOLD - 1);
    localparam logic [7:0] c_FRAME_LAST = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] c_GAP_LAST   = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit         c_HAS_GAP    = (GAP_CYCLES > 0);

    // Parameter legality, reported at elaboration
    generate
        if (START_HOLD < 2 || START_HOLD > 7) begin : g_bad_start_hold
            $error("tx_frame_scheduler: START_HOLD out of range 2..7");
        end
        if (FRAME_CYCLES < 45 || FRAME_CYCLES > 255) begin : g_bad_frame_cycles
            $error("tx_frame_scheduler: FRAME_CYCLES out of range 45..255");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap_cycles
            $error("tx_frame_scheduler: GAP_CYCLES out of range 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_phase_cnt;
    logic        r_last_grant;   // 1 = B owned the last frame, so A wins a tie
    logic        r_tx_start;
    logic [31:0] r_tx_data;
    logic        r_tx_busy;
    logic        r_grant;
    logic        r_frame_done;
    logic [15:0] r_frame_cnt;

    logic        w_idle;
    logic        w_a_ready;
    logic        w_b_ready;

    // Arbitration: ready only in IDLE, tie goes to the side that did not go last
    always_comb begin
        w_idle    = (r_state == S_IDLE) && !reset;
        w_a_ready = w_idle && bus.a_valid && (!bus.b_valid || r_last_grant);
        w_b_ready = w_idle && bus.b_valid && (!bus.a_valid || !r_last_grant);
    end

    // Frame sequencer: IDLE -> START -> WAIT -> GAP -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase_cnt  <= 8'd0;
            r_last_grant <= 1'b1;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 32'd0;
            r_tx_busy    <= 1'b0;
            r_grant      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_a_ready || w_b_ready) begin
                        r_tx_data    <= w_b_ready ? bus.b_data : bus.a_data;
                        r_grant      <= w_b_ready;
                        r_last_grant <= w_b_ready;
                        r_tx_start   <= 1'b1;
                        r_tx_busy    <= 1'b1;
                        r_phase_cnt  <= 8'd0;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    if (r_phase_cnt == c_START_LAST) begin
                        r_tx_start  <= 1'b0;
                        r_phase_cnt <= 8'd0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (r_phase_cnt == c_FRAME_LAST) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 16'd1;
                        r_phase_cnt  <= 8'd0;
                        if (c_HAS_GAP) begin
                            r_state <= S_GAP;
                        end else begin
                            r_tx_busy <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_phase_cnt == c_GAP_LAST) begin
                        r_tx_busy   <= 1'b0;
                        r_phase_cnt <= 8'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.a_ready    = w_a_ready;
    assign bus.b_ready    = w_b_ready;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_busy    = r_tx_busy;
    assign bus.grant      = r_grant;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_frame_scheduler
// Description : Self-checking bench for tx_frame_scheduler. Two instances:
//               default timing (gap 4) and a zero-gap variant. A timeline model
//               predicts every output from the accept edge of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_scheduler;

    localparam int H = 2;
    localparam int F = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        av[2];
    logic        bv[2];
    logic [31:0] ad[2];
    logic [31:0] bd[2];
    int          mode_a[2];
    int          mode_b[2];
    bit          last_acc_a[2];
    bit          last_acc_b[2];

    int n_chk  = 0;
    int n_fail = 0;
    int k      = 0;
    bit chk_en = 1'b0;

    tx_frame_scheduler_if bus0 ();
    tx_frame_scheduler_if bus1 ();

    assign bus0.a_valid = av[0];
    assign bus0.a_data  = ad[0];
    assign bus0.b_valid = bv[0];
    assign bus0.b_data  = bd[0];
    assign bus1.a_valid = av[1];
    assign bus1.a_data  = ad[1];
    assign bus1.b_valid = bv[1];
    assign bus1.b_data  = bd[1];

    tx_frame_scheduler #(.START_HOLD(2), .FRAME_CYCLES(48), .GAP_CYCLES(4)) u_dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    tx_frame_scheduler #(.START_HOLD(2), .FRAME_CYCLES(48), .GAP_CYCLES(0)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    always @(posedge clk) k = k + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual=%h required=%h (edge %0d)", nm, act, exp, k);
        end
    endtask

    // ---------------- timeline model ----------------
    bit          m_have[2];
    int          m_e[2];
    logic [15:0] m_cnt[2];
    logic        m_last[2];
    logic        m_grant[2];
    logic [31:0] m_data[2];

    logic        s_ar[2], s_br[2], s_st[2], s_busy[2], s_gr[2], s_fd[2];
    logic [31:0] s_td[2];
    logic [15:0] s_fc[2];

    always @(negedge clk) begin
        s_ar[0] = bus0.a_ready;  s_br[0] = bus0.b_ready;  s_st[0] = bus0.tx_start;
        s_busy[0] = bus0.tx_busy; s_gr[0] = bus0.grant;   s_fd[0] = bus0.frame_done;
        s_td[0] = bus0.tx_data;  s_fc[0] = bus0.frame_cnt;
        s_ar[1] = bus1.a_ready;  s_br[1] = bus1.b_ready;  s_st[1] = bus1.tx_start;
        s_busy[1] = bus1.tx_busy; s_gr[1] = bus1.grant;   s_fd[1] = bus1.frame_done;
        s_td[1] = bus1.tx_data;  s_fc[1] = bus1.frame_cnt;
        for (int d = 0; d < 2; d++) begin
            int   gp;
            int   t_done;
            bit   idle;
            logic ea, eb, e_st, e_busy, e_fd;
            gp     = (d == 0) ? 4 : 0;
            t_done = m_e[d] + H + F;
            if (m_have[d] && k == t_done) m_cnt[d] = m_cnt[d] + 16'd1;
            idle   = !m_have[d] || (k >= t_done + gp);
            e_st   = m_have[d] && (k >= m_e[d]) && (k <= m_e[d] + H - 1);
            e_busy = m_have[d] && (k >= m_e[d]) && (k < t_done + gp);
            e_fd   = m_have[d] && (k == t_done);
            ea     = !rst && idle && av[d] && (!bv[d] || m_last[d]);
            eb     = !rst && idle && bv[d] && (!av[d] || !m_last[d]);
            if (chk_en) begin
                chk($sformatf("d%0d a_ready", d),    32'(s_ar[d]),   32'(ea));
                chk($sformatf("d%0d b_ready", d),    32'(s_br[d]),   32'(eb));
                chk($sformatf("d%0d tx_start", d),   32'(s_st[d]),   32'(e_st));
                chk($sformatf("d%0d tx_busy", d),    32'(s_busy[d]), 32'(e_busy));
                chk($sformatf("d%0d frame_done", d), 32'(s_fd[d]),   32'(e_fd));
                chk($sformatf("d%0d tx_data", d),    s_td[d],        m_data[d]);
                chk($sformatf("d%0d grant", d),      32'(s_gr[d]),   32'(m_grant[d]));
                chk($sformatf("d%0d frame_cnt", d),  32'(s_fc[d]),   32'(m_cnt[d]));
            end
            if (rst) begin
                m_have[d]  = 1'b0;
                m_e[d]     = 0;
                m_cnt[d]   = 16'd0;
                m_last[d]  = 1'b1;
                m_grant[d] = 1'b0;
                m_data[d]  = 32'd0;
            end else if (ea || eb) begin
                m_have[d]  = 1'b1;
                m_e[d]     = k + 1;
                m_data[d]  = eb ? bd[d] : ad[d];
                m_grant[d] = eb;
                m_last[d]  = eb;
            end
        end
        if (rst) chk_en = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic upd(input int mode, input bit acc, inout logic v, inout logic [31:0] dat);
        if (v && acc) begin
            if (mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1)) begin
                v = 1'b1; dat = $urandom;
            end else begin
                v = 1'b0;
            end
        end else if (mode == 1) begin
            if (!v) begin
                if ($urandom_range(2, 0) == 0) begin v = 1'b1; dat = $urandom; end
            end else if ($urandom_range(7, 0) == 0) begin
                v = 1'($urandom_range(1, 0)); dat = $urandom;
            end
        end else if (mode == 2 && !v) begin
            v = 1'b1; dat = $urandom;
        end
    endtask

    task automatic step();
        logic        v;
        logic [31:0] dat;
        @(negedge clk);
        last_acc_a[0] = av[0] && bus0.a_ready;
        last_acc_b[0] = bv[0] && bus0.b_ready;
        last_acc_a[1] = av[1] && bus1.a_ready;
        last_acc_b[1] = bv[1] && bus1.b_ready;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            v = av[d]; dat = ad[d]; upd(mode_a[d], last_acc_a[d], v, dat); av[d] = v; ad[d] = dat;
            v = bv[d]; dat = bd[d]; upd(mode_b[d], last_acc_b[d], v, dat); bv[d] = v; bd[d] = dat;
        end
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            mode_a[d] = 0; mode_b[d] = 0; av[d] = 1'b0; bv[d] = 1'b0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int d, input bit side, input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            got = side ? last_acc_b[d] : last_acc_a[d];
        end
        chk("accept within bound", 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   kacc[2][$];
        bit   seq[$];
        bit   done;
        for (int d = 0; d < 2; d++) begin
            mode_a[d] = 0; mode_b[d] = 0; av[d] = 1'b0; bv[d] = 1'b0;
            ad[d] = 32'd0; bd[d] = 32'd0;
            m_have[d] = 1'b0; m_e[d] = 0; m_cnt[d] = 16'd0; m_last[d] = 1'b1;
            m_grant[d] = 1'b0; m_data[d] = 32'd0;
        end

        // 1: single A word, literal timing
        do_reset();
        av[0] = 1'b1; ad[0] = 32'hA5A5_1234;
        wait_acc(0, 1'b0, 20);
        chk("t1 tx_start E",   32'(bus0.tx_start), 32'd1);
        chk("t1 tx_data E",    bus0.tx_data, 32'hA5A5_1234);
        step(); chk("t1 tx_start E+1", 32'(bus0.tx_start), 32'd1);
        step(); chk("t1 tx_start E+2", 32'(bus0.tx_start), 32'd0);
        repeat (47) step();
        chk("t1 frame_done early", 32'(bus0.frame_done), 32'd0);
        step();
        chk("t1 frame_done", 32'(bus0.frame_done), 32'd1);
        chk("t1 frame_cnt",  32'(bus0.frame_cnt), 32'd1);
        chk("t1 tx_data held", bus0.tx_data, 32'hA5A5_1234);
        repeat (4) step();
        chk("t1 busy after gap", 32'(bus0.tx_busy), 32'd0);

        // 2: both producers held -> A, B, A
        do_reset();
        mode_a[0] = 2; mode_b[0] = 2; av[0] = 1'b1; bv[0] = 1'b1;
        for (int i = 0; i < 300 && seq.size() < 3; i++) begin
            step();
            if (last_acc_a[0] && last_acc_b[0]) chk("t2 both ready", 32'd1, 32'd0);
            if (last_acc_a[0] || last_acc_b[0]) seq.push_back(last_acc_b[0]);
        end
        chk("t2 grant count", 32'(seq.size()), 32'd3);
        if (seq.size() == 3) begin
            chk("t2 grant 0", 32'(seq[0]), 32'd0);
            chk("t2 grant 1", 32'(seq[1]), 32'd1);
            chk("t2 grant 2", 32'(seq[2]), 32'd0);
        end

        // 3 + 4: B back-to-back on both instances, accept spacing
        do_reset();
        mode_b[0] = 2; mode_b[1] = 2; bv[0] = 1'b1; bv[1] = 1'b1;
        for (int i = 0; i < 300 && (kacc[0].size() < 3 || kacc[1].size() < 3); i++) begin
            step();
            for (int d = 0; d < 2; d++) if (last_acc_b[d]) kacc[d].push_back(k);
        end
        chk("t3 accepts gap4", 32'(kacc[0].size() >= 3), 32'd1);
        chk("t4 accepts gap0", 32'(kacc[1].size() >= 3), 32'd1);
        if (kacc[0].size() >= 3) begin
            chk("t3 spacing 1", 32'(kacc[0][1] - kacc[0][0]), 32'd55);
            chk("t3 spacing 2", 32'(kacc[0][2] - kacc[0][1]), 32'd55);
        end
        if (kacc[1].size() >= 3) begin
            chk("t4 spacing 1", 32'(kacc[1][1] - kacc[1][0]), 32'd51);
            chk("t4 spacing 2", 32'(kacc[1][2] - kacc[1][1]), 32'd51);
        end

        // 5: reset in the middle of a WAIT phase
        do_reset();
        mode_a[0] = 2; av[0] = 1'b1;
        wait_acc(0, 1'b0, 20);
        repeat (70) step();
        chk("t5 frame_cnt before", 32'(bus0.frame_cnt), 32'd1);
        chk("t5 busy before", 32'(bus0.tx_busy), 32'd1);
        mode_a[0] = 0;
        rst = 1'b1;
        step();
        chk("t5 tx_start", 32'(bus0.tx_start), 32'd0);
        chk("t5 tx_busy",  32'(bus0.tx_busy), 32'd0);
        chk("t5 frame_cnt", 32'(bus0.frame_cnt), 32'd0);
        rst = 1'b0;
        av[0] = 1'b1;
        step();
        chk("t5 idle accept", 32'(last_acc_a[0]), 32'd1);

        // 6: frame counter wrap
        do_reset();
        step();
        force u_dut0.r_frame_cnt = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        #1;
        release u_dut0.r_frame_cnt;
        av[0] = 1'b1; ad[0] = $urandom;
        wait_acc(0, 1'b0, 20);
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            done = bus0.frame_done;
        end
        chk("t6 frame_done seen", 32'(done), 32'd1);
        chk("t6 frame_cnt wrap", 32'(bus0.frame_cnt), 32'd0);

        // 7: random traffic on both instances with one reset in between
        do_reset();
        for (int d = 0; d < 2; d++) begin mode_a[d] = 1; mode_b[d] = 1; end
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500 || i == 2333) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
